// File: rtl/pe_array_ctrl_if.sv
// Command and buffer-control bundle between the top level and pe_array_ctrl.
// The master side issues commands; the slave side is the sequencer.
interface pe_array_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             busy;
    logic             done;
    logic             w_rd_en;
    logic [CNT_W-1:0] w_rd_addr;
    logic             d_rd_en;
    logic [CNT_W-1:0] d_rd_addr;
    logic             wwrite;
    logic             active;
    logic             res_valid;
    logic [CNT_W-1:0] res_addr;

    modport master (
        output start, num_vectors,
        input  busy, done, w_rd_en, w_rd_addr, d_rd_en, d_rd_addr,
        input  wwrite, active, res_valid, res_addr
    );

    modport slave (
        input  start, num_vectors,
        output busy, done, w_rd_en, w_rd_addr, d_rd_en, d_rd_addr,
        output wwrite, active, res_valid, res_addr
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for a ROWS x COLS systolic array: weight load, activation
// streaming, then result write-back strobes once the wavefront drains.
module pe_array_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 8
) (
    input logic           clock,
    input logic           reset,
    pe_array_ctrl_if.slave bus
);
    localparam int LAT = ROWS + COLS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_res_addr;
    logic             r_wwrite;
    logic             r_active;
    logic [LAT-1:0]   r_dly;
    logic             w_cmd;
    logic             w_accept;
    logic             w_last;
    logic             w_w_rd_en;
    logic             w_d_rd_en;

    assign w_cmd    = (r_state == S_IDLE) && bus.start;
    assign w_accept = w_cmd && (bus.num_vectors != '0);

    always_comb begin
        w_next    = r_state;
        w_w_rd_en = 1'b0;
        w_d_rd_en = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num_vectors == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_w_rd_en = 1'b1;
                if (r_cnt == CNT_W'(ROWS - 1)) begin
                    w_last = 1'b1;
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_d_rd_en = 1'b1;
                if (r_cnt == r_n - CNT_W'(1)) begin
                    w_last = 1'b1;
                    w_next = S_DRAIN;
                end
            end
            // Leave once the current res_valid is the last one in flight.
            S_DRAIN: begin
                if (!r_active && (r_dly[LAT-2:0] == '0)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_n        <= '0;
            r_res_addr <= '0;
            r_wwrite   <= 1'b0;
            r_active   <= 1'b0;
            r_dly      <= '0;
        end else begin
            if (w_accept) begin
                r_n <= bus.num_vectors;
            end
            if (w_accept || w_last) begin
                r_cnt <= '0;
            end else if (w_w_rd_en || w_d_rd_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_wwrite <= w_w_rd_en;
            r_active <= w_d_rd_en;
            r_dly    <= {r_dly[LAT-2:0], r_active};
            if (w_cmd) begin
                r_res_addr <= '0;
            end else if (r_dly[LAT-1]) begin
                r_res_addr <= r_res_addr + CNT_W'(1);
            end
        end
    end

    assign bus.busy      = (r_state == S_LOAD_W) || (r_state == S_STREAM) ||
                           (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.w_rd_en   = w_w_rd_en;
    assign bus.w_rd_addr = w_w_rd_en ? r_cnt : '0;
    assign bus.d_rd_en   = w_d_rd_en;
    assign bus.d_rd_addr = w_d_rd_en ? r_cnt : '0;
    assign bus.wwrite    = r_wwrite;
    assign bus.active    = r_active;
    assign bus.res_valid = r_dly[LAT-1];
    assign bus.res_addr  = r_res_addr;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl (ROWS=4, COLS=4): expected events are
// queued per channel at command issue and matched by a negedge monitor.
module tb_pe_array_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 8;
    localparam int LAT   = ROWS + COLS - 1;

    typedef struct {
        int c;
        int a;
    } ev_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   b;

    ev_t  q[6][$];
    bit   exp_busy[0:4095];
    bit   zero_chk[0:4095];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pe_array_ctrl_if #(.CNT_W(CNT_W)) bus();

    pe_array_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic push(input int ch, input int c, input int a, input int cut);
        ev_t e;
        if (c <= cut) begin
            e.c = c;
            e.a = a;
            q[ch].push_back(e);
        end
    endtask

    // Issue a command in the current cycle; events after cycle base+cutrel
    // are not expected (used when a reset aborts the run).
    task automatic run(input int n, input int cutrel, output int base);
        int cut;
        base = cyc;
        cut  = base + cutrel;
        bus.start       = 1'b1;
        bus.num_vectors = CNT_W'(n);
        if (n == 0) begin
            push(5, base + 1, 0, cut);
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                push(0, base + 1 + i, i, cut);
                push(1, base + 2 + i, 0, cut);
            end
            for (int i = 0; i < n; i++) begin
                push(2, base + ROWS + 1 + i, i, cut);
                push(3, base + ROWS + 2 + i, 0, cut);
                push(4, base + ROWS + 2 + LAT + i, i, cut);
            end
            push(5, base + ROWS + n + LAT + 2, 0, cut);
            for (int r = 1; r <= ROWS + n + LAT + 1; r++) begin
                if (base + r <= cut) exp_busy[base + r] = 1'b1;
            end
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic chk(input int ch, input string nm, input logic v, input int a);
        bit due;
        due = (q[ch].size() > 0) && (q[ch][0].c == cyc);
        if (v || due) begin
            nvec++;
            if (!v || !due) begin
                nerr++;
                $display("FAIL %s cycle %0d: got strobe=%0b, want strobe=%0b",
                         nm, cyc, v, due);
            end else if (q[ch][0].a != a) begin
                nerr++;
                $display("FAIL %s cycle %0d: got addr=%0d, want addr=%0d",
                         nm, cyc, a, q[ch][0].a);
            end
            if (due) void'(q[ch].pop_front());
        end
    endtask

    always @(negedge clock) begin
        if (cyc > 0 && cyc < 4096) begin
            chk(0, "w_rd",      bus.w_rd_en,   int'(bus.w_rd_addr));
            chk(1, "wwrite",    bus.wwrite,    0);
            chk(2, "d_rd",      bus.d_rd_en,   int'(bus.d_rd_addr));
            chk(3, "active",    bus.active,    0);
            chk(4, "res_valid", bus.res_valid, int'(bus.res_addr));
            chk(5, "done",      bus.done,      0);
            nvec++;
            if (bus.busy !== exp_busy[cyc]) begin
                nerr++;
                $display("FAIL busy cycle %0d: got %0b, want %0b",
                         cyc, bus.busy, exp_busy[cyc]);
            end
            if (zero_chk[cyc]) begin
                nvec++;
                if ({bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr,
                     bus.d_rd_en, bus.d_rd_addr, bus.wwrite, bus.active,
                     bus.res_valid, bus.res_addr} !== 31'd0) begin
                    nerr++;
                    $display("FAIL reset_zero cycle %0d: got nonzero outputs (res_addr=%0d), want all 0",
                             cyc, bus.res_addr);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        zero_chk[cyc + 1] = 1'b1;
        @(negedge clock);

        run(3, 1000, b);
        wait_until(b + 18);

        run(1, 1000, b);
        wait_until(b + 16);

        run(0, 1000, b);
        wait_until(b + 4);

        // Starts during STREAM and DONE must be ignored
        run(3, 1000, b);
        wait_until(b + 6);
        bus.start = 1'b1;
        bus.num_vectors = 8'd5;
        @(negedge clock);
        bus.start = 1'b0;
        wait_until(b + 16);
        bus.start = 1'b1;
        bus.num_vectors = 8'd7;
        @(negedge clock);
        bus.start = 1'b0;
        wait_until(b + 18);

        // Reset in cycle 9 aborts the run
        run(3, 9, b);
        zero_chk[b + 10] = 1'b1;
        wait_until(b + 9);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_until(b + 25);
        run(2, 1000, b);
        wait_until(b + 18);

        // Back-to-back: second start in the first IDLE cycle
        run(3, 1000, b);
        wait_until(b + 17);
        run(2, 1000, b);
        wait_until(b + 20);

        for (int ch = 0; ch < 6; ch++) begin
            while (q[ch].size() > 0) begin
                nvec++;
                nerr++;
                $display("FAIL missing ch%0d: got nothing, want event at cycle %0d addr %0d",
                         ch, q[ch][0].c, q[ch][0].a);
                void'(q[ch].pop_front());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
